// File: rtl/seg7_pattern_engine_if.sv
// ---------------------------------------------------------------------------
// seg7_pattern_engine_if
//
// Purpose: groups the board-side signals of seg7_pattern_engine so that the
// engine, a board wrapper or a bench can pass them around as one bundle.
//
// Signals (all level-sensitive; there is no valid/ready handshake: the
// switches are sampled every clock and the pins are refreshed every clock):
//   en    : 1 = animate, 0 = freeze position (digit scanning continues)
//   cw    : 1 = clockwise (position +1), 0 = counter-clockwise (position -1)
//   mode  : 0 = rotating square, 1 = perimeter chase
//   an    : anode enables, active-low, one-hot-zero, NUM_DIGITS wide
//   seg   : segments, active-low, {dp,g,f,e,d,c,b,a}
//
// Modports:
//   master : the side that owns the switches and watches the pins
//   slave  : the pattern engine itself
// ---------------------------------------------------------------------------
interface seg7_pattern_engine_if #(
  parameter int NUM_DIGITS = 4
);

  logic                  en;
  logic                  cw;
  logic                  mode;
  logic [NUM_DIGITS-1:0] an;
  logic [7:0]            seg;

  modport master (
    output en,
    output cw,
    output mode,
    input  an,
    input  seg
  );

  modport slave (
    input  en,
    input  cw,
    input  mode,
    output an,
    output seg
  );

endinterface

// File: rtl/seg7_pattern_engine.sv
// ---------------------------------------------------------------------------
// seg7_pattern_engine
//
// Purpose: drives an N-digit common-anode multiplexed seven-segment display
// with one of two animations:
//   mode 0 : rotating square (upper square on the way out, lower square on
//            the way back)
//   mode 1 : a single lit segment chasing around the whole display perimeter
//
// Parameters:
//   NUM_DIGITS   : digit count, 2..8; digit 0 is the rightmost
//   SLOW_CLK_DIV : clk cycles per animation step, >= 2
//   REFRESH_DIV  : clk cycles per digit-scan advance, >= 2
//
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : seg7_pattern_engine_if.slave (en, cw, mode in; an, seg out)
//
// Optional feature (compile-time macro SEG7_HEARTBEAT_DP_EN):
//   defined   : a heartbeat bit toggles on every animation step and drives
//               the decimal point of digit 0 (active-low), giving a blink at
//               half the step rate
//   undefined : the decimal point is never lit and no heartbeat bit exists
// ---------------------------------------------------------------------------
module seg7_pattern_engine #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOW_CLK_DIV = 50_000_000,
  parameter int REFRESH_DIV  = 50_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg7_pattern_engine_if.slave bus
);

  // -------------------------------------------------------------------------
  // Widths and constant patterns
  // -------------------------------------------------------------------------
  localparam int POS_W  = $clog2(2 * NUM_DIGITS + 4);
  localparam int SEL_W  = $clog2(NUM_DIGITS);
  localparam int SLOW_W = $clog2(SLOW_CLK_DIV);
  localparam int REF_W  = $clog2(REFRESH_DIV);

  localparam logic [7:0] PAT_UPPER = 8'b1001_1100; // a,b,f,g lit
  localparam logic [7:0] PAT_LOWER = 8'b1010_0011; // c,d,e,g lit
  localparam logic [7:0] PAT_SEG_A = 8'b1111_1110;
  localparam logic [7:0] PAT_SEG_B = 8'b1111_1101;
  localparam logic [7:0] PAT_SEG_C = 8'b1111_1011;
  localparam logic [7:0] PAT_SEG_D = 8'b1111_0111;
  localparam logic [7:0] PAT_SEG_E = 8'b1110_1111;
  localparam logic [7:0] PAT_SEG_F = 8'b1101_1111;
  localparam logic [7:0] PAT_BLANK = 8'hFF;

  // Last legal position for each animation (modulus minus one).
  localparam logic [POS_W-1:0] POS_LAST_SQUARE = POS_W'(2 * NUM_DIGITS - 1);
  localparam logic [POS_W-1:0] POS_LAST_CHASE  = POS_W'(2 * NUM_DIGITS + 3);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [SLOW_W-1:0]     slow_cnt_q, slow_cnt_d;
  logic                  step_tick_q, step_tick_d;
  logic [REF_W-1:0]      ref_cnt_q, ref_cnt_d;
  logic                  scan_tick_q, scan_tick_d;
  logic [SEL_W-1:0]      digit_sel_q, digit_sel_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic                  mode_q, mode_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;
`ifdef SEG7_HEARTBEAT_DP_EN
  logic                  hb_q, hb_d;
`endif

  // -------------------------------------------------------------------------
  // Dividers: each counts 0..DIV-1 and emits a registered one-cycle tick in
  // the cycle after the terminal count, so the tick period is exactly DIV.
  // Both run unconditionally; en only gates the position update.
  // -------------------------------------------------------------------------
  logic slow_wrap;
  logic ref_wrap;

  always_comb begin
    slow_wrap   = (slow_cnt_q == SLOW_W'(SLOW_CLK_DIV - 1));
    slow_cnt_d  = slow_wrap ? '0 : slow_cnt_q + SLOW_W'(1);
    step_tick_d = slow_wrap;

    ref_wrap    = (ref_cnt_q == REF_W'(REFRESH_DIV - 1));
    ref_cnt_d   = ref_wrap ? '0 : ref_cnt_q + REF_W'(1);
    scan_tick_d = ref_wrap;
  end

  // -------------------------------------------------------------------------
  // Digit scan
  // -------------------------------------------------------------------------
  always_comb begin
    digit_sel_d = digit_sel_q;
    if (scan_tick_q) begin
      digit_sel_d = (digit_sel_q == SEL_W'(NUM_DIGITS - 1)) ? '0
                                                            : digit_sel_q + SEL_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Position update. A mode change wins over a simultaneous step and restarts
  // the new animation from position 0, so pos is never interpreted against
  // the wrong modulus. Direction is sampled only at a step, so flipping cw
  // never causes a jump on its own.
  // -------------------------------------------------------------------------
  logic [POS_W-1:0] pos_last;

  always_comb begin
    pos_last = mode_q ? POS_LAST_CHASE : POS_LAST_SQUARE;
    pos_d    = pos_q;
    mode_d   = mode_q;
    if (bus.mode != mode_q) begin
      pos_d  = '0;
      mode_d = bus.mode;
    end else if (bus.en && step_tick_q) begin
      if (bus.cw) begin
        pos_d = (pos_q == pos_last) ? '0 : pos_q + POS_W'(1);
      end else begin
        pos_d = (pos_q == '0) ? pos_last : pos_q - POS_W'(1);
      end
    end
  end

`ifdef SEG7_HEARTBEAT_DP_EN
  // Heartbeat follows the raw step rate, independent of en and mode.
  always_comb begin
    hb_d = step_tick_q ? ~hb_q : hb_q;
  end
`endif

  // -------------------------------------------------------------------------
  // Pattern decode: from (mode_q, pos_q) find the single digit that is lit
  // and what it shows. All other digits are blank.
  // -------------------------------------------------------------------------
  logic [SEL_W-1:0] tgt_digit;
  logic [7:0]       tgt_pat;

  always_comb begin
    tgt_digit = '0;
    tgt_pat   = PAT_BLANK;
    if (!mode_q) begin
      // Square: walks right-to-left... upward on digits 0..N-1, then back
      // over the same digits showing the lower square.
      if (pos_q < POS_W'(NUM_DIGITS)) begin
        tgt_digit = SEL_W'(pos_q);
        tgt_pat   = PAT_UPPER;
      end else begin
        tgt_digit = SEL_W'(POS_LAST_SQUARE - pos_q);
        tgt_pat   = PAT_LOWER;
      end
    end else begin
      // Chase: top edge left to right, down the right side, bottom edge
      // right to left, up the left side.
      if (pos_q < POS_W'(NUM_DIGITS)) begin
        tgt_digit = SEL_W'(POS_W'(NUM_DIGITS - 1) - pos_q);
        tgt_pat   = PAT_SEG_A;
      end else if (pos_q == POS_W'(NUM_DIGITS)) begin
        tgt_digit = '0;
        tgt_pat   = PAT_SEG_B;
      end else if (pos_q == POS_W'(NUM_DIGITS + 1)) begin
        tgt_digit = '0;
        tgt_pat   = PAT_SEG_C;
      end else if (pos_q < POS_W'(2 * NUM_DIGITS + 2)) begin
        tgt_digit = SEL_W'(pos_q - POS_W'(NUM_DIGITS + 2));
        tgt_pat   = PAT_SEG_D;
      end else if (pos_q == POS_W'(2 * NUM_DIGITS + 2)) begin
        tgt_digit = SEL_W'(NUM_DIGITS - 1);
        tgt_pat   = PAT_SEG_E;
      end else begin
        tgt_digit = SEL_W'(NUM_DIGITS - 1);
        tgt_pat   = PAT_SEG_F;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output stage: an and seg are both computed from the same registered
  // state and captured on the same edge, so the pins never show a digit
  // paired with another digit's pattern.
  // -------------------------------------------------------------------------
  always_comb begin
    an_d  = ~(NUM_DIGITS'(1) << digit_sel_q);
    seg_d = (digit_sel_q == tgt_digit) ? tgt_pat : PAT_BLANK;
`ifdef SEG7_HEARTBEAT_DP_EN
    if (digit_sel_q == '0) begin
      seg_d[7] = ~hb_q;
    end
`endif
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slow_cnt_q  <= '0;
      step_tick_q <= 1'b0;
      ref_cnt_q   <= '0;
      scan_tick_q <= 1'b0;
      digit_sel_q <= '0;
      pos_q       <= '0;
      mode_q      <= bus.mode;
      an_q        <= '1;
      seg_q       <= PAT_BLANK;
`ifdef SEG7_HEARTBEAT_DP_EN
      hb_q        <= 1'b0;
`endif
    end else begin
      slow_cnt_q  <= slow_cnt_d;
      step_tick_q <= step_tick_d;
      ref_cnt_q   <= ref_cnt_d;
      scan_tick_q <= scan_tick_d;
      digit_sel_q <= digit_sel_d;
      pos_q       <= pos_d;
      mode_q      <= mode_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
`ifdef SEG7_HEARTBEAT_DP_EN
      hb_q        <= hb_d;
`endif
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;

endmodule

// File: tb/tb_seg7_pattern_engine.sv
// ---------------------------------------------------------------------------
// tb_seg7_pattern_engine
//
// Bench for seg7_pattern_engine with NUM_DIGITS=4, SLOW_CLK_DIV=8,
// REFRESH_DIV=2. The reference model tracks the animation as a position on
// a circular track (modular arithmetic) and paints a per-digit image from a
// perimeter table; the expected pin state for every edge is queued and a
// monitor compares it against the DUT pins shortly after that edge.
// Honours SEG7_HEARTBEAT_DP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_seg7_pattern_engine;

  localparam int N    = 4;
  localparam int SDIV = 8;
  localparam int RDIV = 2;
  localparam int OW   = N + 8;

  // ---------------- clock / reset ----------------
  bit   clk;
  logic rst_n;

  initial forever #5 clk = ~clk;

  seg7_pattern_engine_if #(.NUM_DIGITS(N)) bus ();

  seg7_pattern_engine #(
    .NUM_DIGITS  (N),
    .SLOW_CLK_DIV(SDIV),
    .REFRESH_DIV (RDIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int checks;
  int errors;
  bit drive_done;

  // ---------------- reference model ----------------
  int m_pos, m_sel, m_mode, m_hb;
  int edges;            // clock edges since reset was released
  int per_dig[2*N+4];   // perimeter track: digit at each chase position
  int per_seg[2*N+4];   // perimeter track: segment index (a=0..g=6)

  initial begin
    for (int i = 0; i < N; i++) begin
      per_dig[i] = N - 1 - i;       per_seg[i] = 0;          // top edge, a
      per_dig[N + 2 + i] = i;       per_seg[N + 2 + i] = 3;  // bottom edge, d
    end
    per_dig[N]       = 0;     per_seg[N]       = 1;  // b
    per_dig[N + 1]   = 0;     per_seg[N + 1]   = 2;  // c
    per_dig[2*N + 2] = N - 1; per_seg[2*N + 2] = 4;  // e
    per_dig[2*N + 3] = N - 1; per_seg[2*N + 3] = 5;  // f
  end

  // A tick of period DIV lands on edge k (k counted from 1 after reset)
  // once the first full period has elapsed.
  function automatic bit tick_at(int k, int div);
    return (k - 1 >= div) && ((k - 1) % div == 0);
  endfunction

  function automatic logic [OW-1:0] model_out(int sel, int pos, int md, int hb);
    logic [7:0]   img [N];
    logic [N-1:0] an_exp;
    logic [7:0]   one;
    for (int d = 0; d < N; d++) img[d] = 8'hFF;
    if (md == 0) begin
      if (pos < N) img[pos] = 8'b1001_1100;
      else         img[2*N - 1 - pos] = 8'b1010_0011;
    end else begin
      one = 8'h01;
      img[per_dig[pos]] = ~(one << per_seg[pos]);
    end
`ifdef SEG7_HEARTBEAT_DP_EN
    if (hb != 0) img[0][7] = 1'b0;
`else
    if (hb > 1) img[0] = 8'h00;  // hb is only ever 0/1; never taken
`endif
    an_exp = '1;
    an_exp[sel] = 1'b0;
    return {an_exp, img[sel]};
  endfunction

  // ---------------- driver ----------------
  // Called just after a negedge: applies inputs for the coming posedge,
  // queues the pins expected after it, and advances the model across it.
  task automatic drive_cycle(input bit rst, input bit en, input bit cw, input bit md);
    int p;
    bit step, scan;
    rst_n    = rst ? 1'b1 : 1'b0;
    bus.en   = en;
    bus.cw   = cw;
    bus.mode = md;
    if (!rst) begin
      exp_q.push_back({OW{1'b1}});
      m_pos = 0; m_sel = 0; m_hb = 0; m_mode = int'(md); edges = 0;
    end else begin
      exp_q.push_back(model_out(m_sel, m_pos, m_mode, m_hb));
      edges++;
      step = tick_at(edges, SDIV);
      scan = tick_at(edges, RDIV);
      p = (m_mode == 0) ? 2*N : 2*N + 4;
      if (step) m_hb = 1 - m_hb;
      if (int'(md) != m_mode) begin
        m_pos  = 0;
        m_mode = int'(md);
      end else if (en && step) begin
        m_pos = cw ? (m_pos + 1) % p : (m_pos + p - 1) % p;
      end
      if (scan) m_sel = (m_sel + 1) % N;
    end
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (!drive_done || exp_q.size() != 0) begin
      logic [OW-1:0] exp_v;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pins @%0t: expected queue empty, an=%b seg=%b", $time, bus.an, bus.seg);
      end else begin
        exp_v = exp_q.pop_front();
        if ({bus.an, bus.seg} !== exp_v) begin
          errors++;
          $display("FAIL pins @%0t: got an=%b seg=%b, expected an=%b seg=%b",
                   $time, bus.an, bus.seg, exp_v[OW-1:8], exp_v[7:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit r_en, r_cw, r_md, r_rst;
  bit found;

  initial begin
    checks = 0; errors = 0; drive_done = 0;
    rst_n = 1'b0; bus.en = 1'b0; bus.cw = 1'b1; bus.mode = 1'b0;

    // T1: reset held 3 clocks, then watch the scan walk with animation off.
    repeat (3) drive_cycle(0, 0, 1, 0);
    repeat (12) drive_cycle(1, 0, 1, 0);

    // T2: square clockwise through a full wrap (8+ steps).
    repeat (8 * SDIV + 6) drive_cycle(1, 1, 1, 0);

    // T3: counter-clockwise from position 0 in both modes.
    drive_cycle(0, 1, 0, 0);
    repeat (3 * SDIV) drive_cycle(1, 1, 0, 0);
    drive_cycle(0, 1, 0, 1);
    repeat (3 * SDIV) drive_cycle(1, 1, 0, 1);

    // T4: from square pos 5, flip mode on the very edge a step lands.
    drive_cycle(1, 1, 1, 0);
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (m_mode == 0 && m_pos == 5 && tick_at(edges + 1, SDIV)) found = 1;
      else drive_cycle(1, 1, 1, 0);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mode_switch_setup: pos=%0d never reached 5 at a step, required 5", m_pos);
    end
    repeat (3 * SDIV) drive_cycle(1, 1, 1, 1);

    // T5: freeze across 3+ steps while flipping cw, then resume.
    for (int i = 0; i < 4 * SDIV; i++) drive_cycle(1, 0, (i / 5) % 2 == 0, 1);
    repeat (2 * SDIV) drive_cycle(1, 1, 1, 1);

    // Mid-operation reset.
    drive_cycle(0, 1, 1, 1);
    repeat (2 * SDIV) drive_cycle(1, 1, 1, 1);

    // Random mix of switch activity with rare resets.
    r_en = 1; r_cw = 1; r_md = 1;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 15) == 0)  r_en = ~r_en;
      if ($urandom_range(0, 20) == 0)  r_cw = ~r_cw;
      if ($urandom_range(0, 150) == 0) r_md = ~r_md;
      r_rst = ($urandom_range(0, 599) != 0);
      drive_cycle(r_rst, r_en, r_cw, r_md);
    end

    drive_done = 1;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
